// File: rtl/zap_decode_coproc_mux.sv
// zap_decode_coproc_mux
// Coprocessor dispatch stage in decode. ARM-state MRC/MCR/LDC/STC/CDP
// instructions are routed to one of NUM_CP channels (instr[11:8]), and
// decode stalls until that channel signals done. Absent channels and
// channels that never answer turn the instruction into an undefined trap.
// Everything else passes straight through.

module zap_decode_coproc_mux #(
  parameter int PHY_REGS = 46,
  parameter int NUM_CP   = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [31:0]                 i_instruction,
  input  logic                        i_valid,
  input  logic                        i_irq,
  input  logic                        i_fiq,
  input  logic [31:0]                 i_cpsr_ff,
  input  logic                        i_clear_from_writeback,
  input  logic                        i_clear_from_alu,
  input  logic                        i_stall_from_shifter,
  input  logic                        i_stall_from_issue,
  input  logic                        i_data_stall,
  input  logic                        i_pipeline_dav,
  input  logic [NUM_CP-1:0]           i_cp_present,
  input  logic [NUM_CP-1:0]           i_copro_done,
  output logic [31:0]                 o_instruction,
  output logic                        o_valid,
  output logic                        o_irq,
  output logic                        o_fiq,
  output logic                        o_und,
  output logic                        o_stall_from_decode,
  output logic [NUM_CP-1:0]           o_copro_dav_ff,
  output logic [31:0]                 o_copro_word_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_copro_reg_ff,
  output logic [31:0]                 o_copro_mode_ff,
  output logic                        o_copro_timeout
);

  localparam int RW = $clog2(PHY_REGS);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  // Processor mode encodings (CPSR[4:0])
  localparam logic [4:0] MODE_FIQ = 5'h11;
  localparam logic [4:0] MODE_IRQ = 5'h12;
  localparam logic [4:0] MODE_SVC = 5'h13;
  localparam logic [4:0] MODE_ABT = 5'h17;
  localparam logic [4:0] MODE_UND = 5'h1B;

  typedef enum logic [1:0] {IDLE, BUSY, TRAP} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [31:0]       held_reg, held_next;
  logic              timeout_reg, timeout_next;
  logic [NUM_CP-1:0] dav_next;
  logic [31:0]       word_next;
  logic [RW-1:0]     reg_next;
  logic [31:0]       mode_next;

  logic [NUM_CP-1:0] ch_onehot;
  logic              present_ok;
  logic              done_sel;
  logic              is_cp;
  logic              is_mcr_mrc;
  logic [3:0]        reg_sel;
  logic              unused_ok;

  // Architectural register -> physical register for the given mode.
  // Banked registers live above the shared R0-R15 / RAZ slots.
  function automatic logic [RW-1:0] translate(input logic [3:0] r, input logic [4:0] m);
    int idx;
    idx = int'(r);
    case (m)
      MODE_FIQ: begin
        if (r >= 4'd8 && r <= 4'd14) idx = 17 + int'(r) - 8;
      end
      MODE_IRQ: begin
        if (r == 4'd13) idx = 24;
        else if (r == 4'd14) idx = 25;
      end
      MODE_SVC: begin
        if (r == 4'd13) idx = 26;
        else if (r == 4'd14) idx = 27;
      end
      MODE_UND: begin
        if (r == 4'd13) idx = 28;
        else if (r == 4'd14) idx = 29;
      end
      MODE_ABT: begin
        if (r == 4'd13) idx = 30;
        else if (r == 4'd14) idx = 31;
      end
      default: idx = int'(r);
    endcase
    return RW'(idx);
  endfunction

  // Decode the channel number into a one-hot; numbers >= NUM_CP decode to zero
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CP; gi++) begin : g_ch
      assign ch_onehot[gi] = (i_instruction[11:8] == 4'(gi));
    end
  endgenerate

  assign present_ok = |(ch_onehot & i_cp_present);
  // Only the done bit of the channel currently requested is honoured
  assign done_sel   = |(i_copro_done & o_copro_dav_ff);
  assign is_cp      = i_valid & ~i_cpsr_ff[5] &
                      ((i_instruction[27:24] == 4'b1110) | (i_instruction[27:25] == 3'b110));
  assign is_mcr_mrc = (i_instruction[27:24] == 4'b1110) & i_instruction[4];
  assign reg_sel    = is_mcr_mrc ? i_instruction[15:12] : i_instruction[19:16];

  assign o_copro_timeout = timeout_reg;
  assign unused_ok       = &{1'b0, i_data_stall};

  // State and request registers: async reset, sync clears, freeze on stall
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      held_reg        <= '0;
      timeout_reg     <= 1'b0;
      o_copro_dav_ff  <= '0;
      o_copro_word_ff <= '0;
      o_copro_reg_ff  <= '0;
      o_copro_mode_ff <= '0;
    end else if (i_clear_from_writeback || i_clear_from_alu) begin
      state_reg       <= IDLE;
      count_reg       <= '0;
      held_reg        <= '0;
      timeout_reg     <= 1'b0;
      o_copro_dav_ff  <= '0;
      o_copro_word_ff <= '0;
      o_copro_reg_ff  <= '0;
      o_copro_mode_ff <= '0;
    end else if (!(i_stall_from_shifter || i_stall_from_issue)) begin
      state_reg       <= state_next;
      count_reg       <= count_next;
      held_reg        <= held_next;
      timeout_reg     <= timeout_next;
      o_copro_dav_ff  <= dav_next;
      o_copro_word_ff <= word_next;
      o_copro_reg_ff  <= reg_next;
      o_copro_mode_ff <= mode_next;
    end
  end

  // Next-state logic and downstream/stall outputs
  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    held_next    = held_reg;
    timeout_next = 1'b0;
    dav_next     = o_copro_dav_ff;
    word_next    = o_copro_word_ff;
    reg_next     = o_copro_reg_ff;
    mode_next    = o_copro_mode_ff;

    o_instruction       = i_valid ? i_instruction : 32'd0;
    o_valid             = i_valid;
    o_irq               = i_valid & i_irq;
    o_fiq               = i_valid & i_fiq;
    o_und               = 1'b0;
    o_stall_from_decode = 1'b0;

    case (state_reg)
      IDLE: begin
        if (is_cp) begin
          // Hold the instruction upstream until it is dispatched or trapped
          o_valid             = 1'b0;
          o_irq               = 1'b0;
          o_fiq               = 1'b0;
          o_stall_from_decode = 1'b1;
          if (!i_pipeline_dav) begin
            if (present_ok) begin
              state_next = BUSY;
              dav_next   = ch_onehot;
              word_next  = i_instruction;
              mode_next  = i_cpsr_ff;
              reg_next   = translate(reg_sel, i_cpsr_ff[4:0]);
              count_next = '0;
            end else begin
              state_next = TRAP;
              held_next  = i_instruction;
            end
          end
        end
      end

      BUSY: begin
        o_valid             = 1'b0;
        o_irq               = 1'b0;
        o_fiq               = 1'b0;
        o_stall_from_decode = 1'b1;
        if (done_sel) begin
          // Done beats a coincident timeout; release decode right away
          state_next          = IDLE;
          dav_next            = '0;
          word_next           = '0;
          o_stall_from_decode = 1'b0;
        end else if (count_reg == LAST_COUNT) begin
          state_next   = TRAP;
          held_next    = o_copro_word_ff;
          dav_next     = '0;
          word_next    = '0;
          timeout_next = 1'b1;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end

      TRAP: begin
        // Emit the held word as an undefined instruction for one cycle
        o_instruction = held_reg;
        o_valid       = 1'b1;
        o_und         = 1'b1;
        o_irq         = 1'b0;
        o_fiq         = 1'b0;
        state_next    = IDLE;
        held_next     = '0;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
